reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised register file for the pipelined MIPS datapath, with a per-register scoreboard.
- Two asynchronous read ports and one synchronous write port.
- Busy bits are set at instruction issue ("reserve") and cleared at writeback, so the hazard unit can stall on RAW dependencies.
- Contents are cleared after reset by a sweep FSM rather than an initial block, so the array is synthesisable as RAM.

Parameters:
DATA_W, 32, data width of each register
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
initDone  out  1  high once the clear sweep has finished; the block accepts traffic only while high
readReg1  in  ADDR_W  read port 1 address
readDat1  out  DATA_W  read port 1 data (combinational)
readBusy1  out  1  busy bit of readReg1 (combinational)
readReg2  in  ADDR_W  read port 2 address
readDat2  out  DATA_W  read port 2 data (combinational)
readBusy2  out  1  busy bit of readReg2 (combinational)
regWrite  in  1  write enable
writeReg  in  ADDR_W  write address
writeData  in  DATA_W  write data
reserve  in  1  mark reserveReg busy (issue of an instruction that writes it)
reserveReg  in  ADDR_W  register to reserve
pendingCount  out  ADDR_W+1  number of busy registers

Behaviour:
- The whole block is only specified when clocked by clk; there are no other clocks.
- FSM states: CLEAR, RUN.
- rst sampled high at a posedge sets, at that edge:
  - state = CLEAR, clrIdx = 0
  - all busy bits = 0, pendingCount = 0, initDone = 0
- This applies identically when rst arrives mid-sweep or mid-operation: the sweep restarts from index 0.
- CLEAR state:
  - Each posedge with rst low writes registers[clrIdx] = 0 and increments clrIdx.
  - At the edge that clears index DEPTH-1, state becomes RUN and initDone = 1.
  - initDone is therefore first high after the DEPTH-th edge following rst deassertion (32 edges by default).
  - regWrite and reserve are ignored.
  - readDat1/2 = 0 and readBusy1/2 = 0.
- RUN state, reads:
  - readDatN = registers[readRegN] and readBusyN = busy[readRegN], both combinational.
  - With ZERO_REG=1, address 0 always returns data 0 and busy 0.
- RUN state, write:
  - On posedge with regWrite = 1: registers[writeReg] = writeData and busy[writeReg] is cleared.
  - With ZERO_REG=1, a write to address 0 is a no-op.
  - A write to a non-busy register is legal: data is updated and pendingCount is unchanged.
- RUN state, reserve:
  - On posedge with reserve = 1, busy[reserveReg] is set.
  - Reserving an already-busy register (WAW) leaves the bit set and pendingCount unchanged.
  - With ZERO_REG=1, reserving address 0 is ignored.
- Simultaneous write and reserve to the same register in one cycle:
  - Data is written and the busy bit ends up set, because reserve wins.
  - pendingCount is unchanged if the register was already busy; +1 if it was not.
- pendingCount is updated at each posedge:
  - +1 for each busy bit that goes 0→1.
  - −1 for each busy bit that goes 1→0.
  - Net 0 when both happen in the same cycle.
  - The count never wraps; its range is 0..DEPTH.
- Read-during-write with BYPASS_EN undefined: the read returns the old value until the edge, and readBusy shows the pre-edge bit.
- Latency: write-to-read is 1 edge; reserve-to-busy-visible is 1 edge.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: in RUN, if regWrite = 1 and writeReg == readRegN (and the address is nonzero when ZERO_REG=1), then:
  - readDatN = writeData in the same cycle;
  - readBusyN = 0, unless reserve = 1 and reserveReg == readRegN in that cycle, in which case readBusyN = 1.
- Not defined: no forwarding; behaviour is exactly as in Behaviour above.

Test Plan:
- Reset sweep: rst high 1 cycle, then low. initDone = 0 for 31 edges and 1 after edge 32. Reads of registers 0..31 return 0 and pendingCount = 0. Writes attempted during the sweep have no effect.
- Write/read: write reg 5 = 0xDEADBEEF, then read on both ports. readDat = 0xDEADBEEF one edge later. Write reg 0 = 0x1234: reg 0 still reads 0.
- Scoreboard: reserve reg 7 → readBusy = 1, pendingCount = 1. Reserve 7 again → count still 1. Write 7 = 0x55 → busy = 0, count = 0, data = 0x55.
- Same-cycle events:
  - Busy reg 3: reserve 3 + write 3 in one cycle → busy stays 1, count unchanged, data updated.
  - reserve 4 + write busy 9 in one cycle → count unchanged, busy[4] = 1, busy[9] = 0.
- Reset mid-operation: with 3 registers busy and non-zero data, assert rst. Count = 0, initDone = 0, the sweep completes in 32 edges, and all data reads 0.
- Bypass, REGFILE_BYPASS_EN defined: readReg1 = writeReg = 12, writeData = 0xA5A5A5A5. readDat1 = 0xA5A5A5A5 in the same cycle. With the macro undefined, readDat1 = the old value until the edge.

Source files
------------

// File: rtl/reg_file_sb.sv
//------------------------------------------------------------------------------
// reg_file_sb : 2R/1W register file with per-register busy scoreboard and
//               post-reset clear sweep. Optional macro: REGFILE_BYPASS_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              initDone,
  input  logic [ADDR_W-1:0] readReg1,
  output logic [DATA_W-1:0] readDat1,
  output logic              readBusy1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readDat2,
  output logic              readBusy2,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserveReg,
  output logic [ADDR_W:0]   pendingCount
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_clrIdx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   r_pending;

  logic              w_run;
  logic              w_wr_en;
  logic              w_rsv_en;
  logic              w_set;
  logic              w_clr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;

  assign w_run    = (r_state == S_RUN);
  assign w_wr_en  = w_run && regWrite && !((ZERO_REG != 0) && (writeReg == '0));
  assign w_rsv_en = w_run && reserve  && !((ZERO_REG != 0) && (reserveReg == '0));

  // Count moves only on real busy transitions; reserve wins over a same-register write.
  assign w_set = w_rsv_en && !r_busy[reserveReg];
  assign w_clr = w_wr_en && r_busy[writeReg] && !(w_rsv_en && (reserveReg == writeReg));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_CLEAR;
      r_clrIdx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) begin
        r_clrIdx <= r_clrIdx + 1'b1;
      end
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (&r_clrIdx) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // FSM: outputs
  always_comb begin
    initDone = (r_state == S_RUN);
  end

  // Single write port shared by the clear sweep and normal writeback keeps the array RAM-mappable.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = writeReg;
    w_mem_data = writeData;
    if (!w_run) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clrIdx;
      w_mem_data = '0;
    end else if (w_wr_en) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_en)  w_busy_nxt[writeReg]   = 1'b0;
    if (w_rsv_en) w_busy_nxt[reserveReg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_pending <= r_pending + {{ADDR_W{1'b0}}, w_set} - {{ADDR_W{1'b0}}, w_clr};
    end
  end

  assign pendingCount = r_pending;

  always_comb begin
    readDat1  = '0;
    readBusy1 = 1'b0;
    if (w_run && !((ZERO_REG != 0) && (readReg1 == '0))) begin
      readDat1  = r_mem[readReg1];
      readBusy1 = r_busy[readReg1];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (writeReg == readReg1)) begin
        readDat1  = writeData;
        readBusy1 = w_rsv_en && (reserveReg == readReg1);
      end
`endif
    end
  end

  always_comb begin
    readDat2  = '0;
    readBusy2 = 1'b0;
    if (w_run && !((ZERO_REG != 0) && (readReg2 == '0))) begin
      readDat2  = r_mem[readReg2];
      readBusy2 = r_busy[readReg2];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (writeReg == readReg2)) begin
        readDat2  = writeData;
        readBusy2 = w_rsv_en && (reserveReg == readReg2);
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
//------------------------------------------------------------------------------
// tb_reg_file_sb : directed bench for reg_file_sb with queued expectations.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam int K_INIT = 0;
  localparam int K_DAT1 = 1;
  localparam int K_DAT2 = 2;
  localparam int K_BSY1 = 3;
  localparam int K_BSY2 = 4;
  localparam int K_PEND = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              initDone;
  logic [ADDR_W-1:0] readReg1;
  logic [DATA_W-1:0] readDat1;
  logic              readBusy1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readDat2;
  logic              readBusy2;
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              reserve;
  logic [ADDR_W-1:0] reserveReg;
  logic [ADDR_W:0]   pendingCount;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .initDone(initDone),
    .readReg1(readReg1), .readDat1(readDat1), .readBusy1(readBusy1),
    .readReg2(readReg2), .readDat2(readDat2), .readBusy2(readBusy2),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .reserve(reserve), .reserveReg(reserveReg), .pendingCount(pendingCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_INIT:  return "initDone";
      K_DAT1:  return "readDat1";
      K_DAT2:  return "readDat2";
      K_BSY1:  return "readBusy1";
      K_BSY2:  return "readBusy2";
      default: return "pendingCount";
    endcase
  endfunction

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        K_INIT:  act = {31'd0, initDone};
        K_DAT1:  act = readDat1;
        K_DAT2:  act = readDat2;
        K_BSY1:  act = {31'd0, readBusy1};
        K_BSY2:  act = {31'd0, readBusy2};
        default: act = {26'd0, pendingCount};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h at %0t", kname(e.kind), act, e.exp, $time);
      end
    end
  end

  task automatic expect_v(input int k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    regWrite = 1'b0; writeReg = '0; writeData = '0;
    reserve  = 1'b0; reserveReg = '0;
  endtask

  task automatic sweep_and_scan();
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 32) idle_inputs();
      expect_v(K_INIT, (k == 32) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 32; i++) begin
      step();
      readReg1 = ADDR_W'(i);
      readReg2 = ADDR_W'(31 - i);
      expect_v(K_DAT1, 32'd0);
      expect_v(K_DAT2, 32'd0);
      expect_v(K_BSY1, 32'd0);
    end
    expect_v(K_PEND, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    readReg1 = '0;
    readReg2 = '0;
    idle_inputs();
    step();
    rst = 1'b0;
    expect_v(K_INIT, 32'd0);
    expect_v(K_PEND, 32'd0);
    expect_v(K_DAT1, 32'd0);
    expect_v(K_BSY1, 32'd0);
    // Traffic during the sweep must be ignored.
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hFFFF_FFFF;
    reserve  = 1'b1; reserveReg = 5'd6;
    sweep_and_scan();

    // Write / read
    step();
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEAD_BEEF;
    readReg1 = 5'd5; readReg2 = 5'd5;
    expect_v(K_DAT1, BYP ? 32'hDEAD_BEEF : 32'd0);
    step();
    idle_inputs();
    expect_v(K_DAT1, 32'hDEAD_BEEF);
    expect_v(K_DAT2, 32'hDEAD_BEEF);
    expect_v(K_PEND, 32'd0);

    step();
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234;
    readReg1 = 5'd0;
    expect_v(K_DAT1, 32'd0);
    step();
    idle_inputs();
    expect_v(K_DAT1, 32'd0);

    // Reserve / WAW / writeback
    step();
    reserve = 1'b1; reserveReg = 5'd7; readReg1 = 5'd7;
    expect_v(K_BSY1, 32'd0);
    expect_v(K_PEND, 32'd0);
    step();
    expect_v(K_BSY1, 32'd1);
    expect_v(K_PEND, 32'd1);
    step();
    idle_inputs();
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h55;
    expect_v(K_PEND, 32'd1);
    expect_v(K_BSY1, BYP ? 32'd0 : 32'd1);
    step();
    idle_inputs();
    expect_v(K_BSY1, 32'd0);
    expect_v(K_PEND, 32'd0);
    expect_v(K_DAT1, 32'h55);

    // Same-cycle reserve + write of busy reg 3
    step();
    reserve = 1'b1; reserveReg = 5'd3;
    step();
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h33;
    readReg1 = 5'd3;
    expect_v(K_PEND, 32'd1);
    expect_v(K_BSY1, 32'd1);
    step();
    idle_inputs();
    expect_v(K_BSY1, 32'd1);
    expect_v(K_PEND, 32'd1);
    expect_v(K_DAT1, 32'h33);

    // Reserve 4 while writing back busy 9
    step();
    reserve = 1'b1; reserveReg = 5'd9;
    step();
    idle_inputs();
    expect_v(K_PEND, 32'd2);
    reserve = 1'b1; reserveReg = 5'd4;
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h99;
    step();
    idle_inputs();
    readReg1 = 5'd4; readReg2 = 5'd9;
    expect_v(K_BSY1, 32'd1);
    expect_v(K_BSY2, 32'd0);
    expect_v(K_PEND, 32'd2);
    expect_v(K_DAT2, 32'h99);

    // Reserving register 0 is ignored
    step();
    reserve = 1'b1; reserveReg = 5'd0;
    step();
    idle_inputs();
    readReg1 = 5'd0;
    expect_v(K_BSY1, 32'd0);
    expect_v(K_PEND, 32'd2);

    // Third busy register, then reset mid-operation
    step();
    reserve = 1'b1; reserveReg = 5'd10;
    step();
    idle_inputs();
    expect_v(K_PEND, 32'd3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    readReg1 = 5'd4;
    expect_v(K_PEND, 32'd0);
    expect_v(K_INIT, 32'd0);
    expect_v(K_BSY1, 32'd0);
    sweep_and_scan();

    // Read-during-write on register 12
    step();
    regWrite = 1'b1; writeReg = 5'd12; writeData = 32'hA5A5_A5A5;
    readReg1 = 5'd12;
    expect_v(K_DAT1, BYP ? 32'hA5A5_A5A5 : 32'd0);
    expect_v(K_BSY1, 32'd0);
    step();
    idle_inputs();
    expect_v(K_DAT1, 32'hA5A5_A5A5);

    step();
    step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expectations expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
